plc_check_scheduler: RTL and testbench
======================================

// Module: plc_check_scheduler
// PURPOSE
//  Sequences PLC list checks. Launches a check periodically or on request, and shares the dcache read port between core and checker.
//  Forces a bounded core stall when checker is starved, and accumulates checker error reports.
//  Sits between core pipeline, plc_list/plc_checker, and the dcache port mux.
// PARAMETERS
//  INTERVAL_W    16  width of cfg_interval (cycles between periodic launches)
//  STARVE_W      8   width of cfg_starve_limit / starvation counter
//  STALL_CYCLES  4   cycles the core is held off per forced stall (>=1)
//  ERR_CNT_W     8   width of saturating error counter
//  TIMEOUT_CYCLES 1024  watchdog limit (PLC_SCHED_TIMEOUT_EN only)
// PORTS
//  clk              in  1          clock
//  rst_n            in  1          async reset, active low
//  cfg_enable       in  1          scheduler enable
//  cfg_interval     in  INTERVAL_W launch period in cycles; 0 = no periodic launch
//  cfg_starve_limit in  STARVE_W   denied-cycle limit before forced stall; 0 = never stall
//  force_check      in  1          one-cycle request for immediate check
//  list_nonempty    in  1          PLC list holds >=1 entry
//  core_access      in  1          core read_enable|write_enable this cycle
//  chk_done         in  1          checker finished (last entry consumed)
//  chk_error        in  1          checker error pulse
//  err_clr          in  1          clears err_irq and err_count
//  chk_start        out 1          one-cycle checker start pulse
//  chk_grant        out 1          cache port to checker this cycle (mux select)
//  core_stall       out 1          core must not access cache while high
//  busy             out 1          state is START, RUN or STALL
//  err_count        out ERR_CNT_W  saturating count of chk_error pulses
//  err_irq          out 1          sticky error flag
//  timeout_err      out 1          watchdog pulse (PLC_SCHED_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0, all outputs 0. Reset mid-check drops the check silently.
//  Outputs are Moore/registered except chk_grant in RUN (= !core_access, combinational).
//  IDLE: cfg_enable=1 -> COUNT, ivl_cnt=0. force_check is ignored in IDLE.
//  COUNT: ivl_cnt++ each cycle. Launch condition: (cfg_interval!=0 && ivl_cnt==cfg_interval-1) || force_check || pend.
//   Launch && list_nonempty -> START. Launch && !list_nonempty -> ivl_cnt=0, pend=0, stay.
//   cfg_enable=0 -> IDLE (takes priority over launch).
//  START: chk_start=1 for exactly one cycle, ivl_cnt=0, starve=0 -> RUN.
//  RUN: chk_grant=!core_access. starve++ on each core_access cycle; reset to 0 on each granted cycle.
//   cfg_starve_limit!=0 && starve==cfg_starve_limit -> STALL.
//   chk_done -> COUNT (or IDLE if cfg_enable=0). chk_done has priority over the stall transition.
//  STALL: core_stall=1, chk_grant=1 for STALL_CYCLES cycles -> RUN with starve=0.
//   chk_done in STALL -> exit as in RUN; core_stall drops the next cycle.
//  force_check during START/RUN/STALL sets pend. The next launch follows chk_done immediately: one COUNT cycle, then START.
//  Simultaneous force_check and interval expiry -> single launch.
//  cfg_enable deassert during START/RUN/STALL: check completes, then IDLE. pend is cleared on IDLE.
//  err_count: +1 per chk_error, saturates at all-ones. err_irq set by chk_error.
//   err_clr clears both. Same-cycle chk_error and err_clr -> err_count=1, err_irq=1.
//  Core contract: core_access==0 whenever core_stall==1 (bench asserts this).
// CONFIGURATION
//  PLC_SCHED_TIMEOUT_EN defined: watchdog counts cycles in RUN+STALL.
//   Reaching TIMEOUT_CYCLES without chk_done gives timeout_err=1 for one cycle, state -> COUNT, chk_grant/core_stall -> 0.
//   Same-cycle timeout and chk_done: chk_done wins, no timeout_err.
//  Macro undefined: no watchdog and no timeout_err port; RUN waits indefinitely for chk_done.
// TESTING
//  1 cfg_interval=10, list_nonempty=1, no core traffic -> chk_start pulses at cycles 10,21,32...
//    chk_done is given 1 cycle after start; chk_grant=1 throughout RUN.
//  2 list_nonempty=0, cfg_interval=5 -> chk_start never asserts; ivl_cnt wraps every 5 cycles.
//  3 RUN, core_access held 1, cfg_starve_limit=3, STALL_CYCLES=4 -> chk_grant=0 for 3 cycles.
//    Then core_stall=1 and chk_grant=1 for exactly 4 cycles, then back to RUN.
//  4 force_check during RUN, chk_done 5 cycles later -> second chk_start 2 cycles after chk_done; single pulse only.
//  5 chk_error x300 with ERR_CNT_W=8 -> err_count=255, err_irq=1.
//    chk_error with err_clr same cycle -> err_count=1.
//  6 rst_n low mid-STALL -> core_stall, chk_grant, busy low immediately.
//    With PLC_SCHED_TIMEOUT_EN, withheld chk_done -> timeout_err pulse at cycle TIMEOUT_CYCLES of the check.

Source files
------------

// File: rtl/plc_check_scheduler.sv
// rtl/plc_check_scheduler.sv - PLC check sequencer: periodic/forced launch, dcache port sharing, starvation stall, error accounting
// Optional watchdog on RUN/STALL enabled by defining PLC_SCHED_TIMEOUT_EN.
module plc_check_scheduler #(
    parameter int INTERVAL_W     = 16,
    parameter int STARVE_W       = 8,
    parameter int STALL_CYCLES   = 4,
    parameter int ERR_CNT_W      = 8
`ifdef PLC_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic [INTERVAL_W-1:0] cfg_interval,
    input  logic [STARVE_W-1:0]   cfg_starve_limit,
    input  logic                  force_check,
    input  logic                  list_nonempty,
    input  logic                  core_access,
    input  logic                  chk_done,
    input  logic                  chk_error,
    input  logic                  err_clr,
    output logic                  chk_start,
    output logic                  chk_grant,
    output logic                  core_stall,
    output logic                  busy,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic                  err_irq
`ifdef PLC_SCHED_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    localparam int SC_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_STALL = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [INTERVAL_W-1:0] ivl_cnt_q, ivl_cnt_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [SC_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic                  pend_q, pend_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic                  err_irq_q, err_irq_d;

    logic [INTERVAL_W-1:0] ivl_last;
    logic [INTERVAL_W-1:0] ivl_run;
    logic [STARVE_W-1:0]   starve_next;
    logic                  ivl_hit;
    logic                  launch;
    state_t                exit_state;

`ifdef PLC_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    assign ivl_last   = cfg_interval - INTERVAL_W'(1);
    assign ivl_hit    = (cfg_interval != '0) && (ivl_cnt_q == ivl_last);
    assign launch     = ivl_hit || force_check || pend_q;
    assign exit_state = cfg_enable ? S_COUNT : S_IDLE;

    // While a check runs the interval keeps counting but parks at its last value,
    // so an overlong check relaunches right after its first COUNT cycle instead of wrapping.
    assign ivl_run = ivl_hit ? ivl_cnt_q : ivl_cnt_q + INTERVAL_W'(1);

    always_comb begin
        starve_next = '0;
        if (core_access) begin
            starve_next = (starve_q == '1) ? starve_q : starve_q + STARVE_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        ivl_cnt_d   = ivl_cnt_q;
        starve_d    = starve_q;
        stall_cnt_d = stall_cnt_q;
        pend_d      = pend_q;
`ifdef PLC_SCHED_TIMEOUT_EN
        wdog_d        = wdog_q;
        timeout_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (cfg_enable) begin
                    state_d   = S_COUNT;
                    ivl_cnt_d = '0;
                end
            end

            S_COUNT: begin
                if (!cfg_enable) begin
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                end else if (launch) begin
                    pend_d    = 1'b0;
                    ivl_cnt_d = '0;
                    if (list_nonempty) begin
                        state_d = S_START;
                    end
                end else begin
                    ivl_cnt_d = ivl_cnt_q + INTERVAL_W'(1);
                end
            end

            S_START: begin
                ivl_cnt_d = '0;
                starve_d  = '0;
                state_d   = S_RUN;
                if (force_check) begin
                    pend_d = 1'b1;
                end
`ifdef PLC_SCHED_TIMEOUT_EN
                wdog_d = WD_W'(1);
`endif
            end

            S_RUN: begin
                ivl_cnt_d = ivl_run;
                starve_d  = starve_next;
                if (force_check) begin
                    pend_d = 1'b1;
                end
                if (chk_done) begin
                    state_d = exit_state;
                end else if ((cfg_starve_limit != '0) && (starve_next == cfg_starve_limit)) begin
                    state_d     = S_STALL;
                    stall_cnt_d = '0;
                end
            end

            S_STALL: begin
                ivl_cnt_d = ivl_run;
                starve_d  = '0;
                if (force_check) begin
                    pend_d = 1'b1;
                end
                if (chk_done) begin
                    state_d = exit_state;
                end else if (stall_cnt_q == SC_W'(STALL_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    stall_cnt_d = stall_cnt_q + SC_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PLC_SCHED_TIMEOUT_EN
        // START counts as the first cycle of the check; chk_done on the final cycle beats the watchdog.
        if ((state_q == S_RUN) || (state_q == S_STALL)) begin
            wdog_d = wdog_q + WD_W'(1);
            if (!chk_done && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
                state_d       = S_COUNT;
                timeout_err_d = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        err_count_d = err_count_q;
        err_irq_d   = err_irq_q;
        if (err_clr) begin
            err_count_d = chk_error ? ERR_CNT_W'(1) : '0;
            err_irq_d   = chk_error;
        end else if (chk_error) begin
            err_irq_d = 1'b1;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ivl_cnt_q   <= '0;
            starve_q    <= '0;
            stall_cnt_q <= '0;
            pend_q      <= 1'b0;
            err_count_q <= '0;
            err_irq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ivl_cnt_q   <= ivl_cnt_d;
            starve_q    <= starve_d;
            stall_cnt_q <= stall_cnt_d;
            pend_q      <= pend_d;
            err_count_q <= err_count_d;
            err_irq_q   <= err_irq_d;
        end
    end

`ifdef PLC_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    // Only the RUN grant follows core_access combinationally; everything else decodes the state register.
    assign chk_start  = (state_q == S_START);
    assign core_stall = (state_q == S_STALL);
    assign busy       = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_STALL);
    assign chk_grant  = ((state_q == S_RUN) && !core_access) || (state_q == S_STALL);
    assign err_count  = err_count_q;
    assign err_irq    = err_irq_q;

endmodule

// File: tb/tb_plc_check_scheduler.sv
// tb/tb_plc_check_scheduler.sv - table-driven bench for plc_check_scheduler
module tb_plc_check_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable;
    logic [15:0] cfg_interval;
    logic [7:0]  cfg_starve_limit;
    logic        force_check;
    logic        list_nonempty;
    logic        core_access;
    logic        chk_done;
    logic        chk_error;
    logic        err_clr;
    logic        chk_start;
    logic        chk_grant;
    logic        core_stall;
    logic        busy;
    logic [7:0]  err_count;
    logic        err_irq;
`ifdef PLC_SCHED_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 clk = ~clk;

    plc_check_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_enable       (cfg_enable),
        .cfg_interval     (cfg_interval),
        .cfg_starve_limit (cfg_starve_limit),
        .force_check      (force_check),
        .list_nonempty    (list_nonempty),
        .core_access      (core_access),
        .chk_done         (chk_done),
        .chk_error        (chk_error),
        .err_clr          (err_clr),
        .chk_start        (chk_start),
        .chk_grant        (chk_grant),
        .core_stall       (core_stall),
        .busy             (busy),
        .err_count        (err_count),
        .err_irq          (err_irq)
`ifdef PLC_SCHED_TIMEOUT_EN
        ,
        .timeout_err      (timeout_err)
`endif
    );

    // expected {chk_start, chk_grant, core_stall, busy}
    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] ST = 4'b1001;
    localparam logic [3:0] GR = 4'b0101;
    localparam logic [3:0] RN = 4'b0001;
    localparam logic [3:0] SL = 4'b0111;

    typedef struct {
        int          n;
        logic        en;
        logic [15:0] ivl;
        logic        fc;
        logic        ne;
        logic        ca;
        logic        done;
        logic [3:0]  exp;
    } vec_t;

    vec_t tbl[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input int n, input logic en, input logic [15:0] ivl, input logic fc,
                                input logic ne, input logic ca, input logic done, input logic [3:0] exp);
        vec_t v;
        v.n = n; v.en = en; v.ivl = ivl; v.fc = fc; v.ne = ne; v.ca = ca; v.done = done; v.exp = exp;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic [3:0] got;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            cfg_enable    = v.en;
            cfg_interval  = v.ivl;
            force_check   = v.fc;
            list_nonempty = v.ne;
            core_access   = v.ca;
            chk_done      = v.done;
            #1;
            got = {chk_start, chk_grant, core_stall, busy};
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: {start,grant,stall,busy} got %b want %b", tag, i, got, v.exp);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && core_stall && core_access) begin
            miscompares++;
            $display("FAIL core_contract: core_access=1 while core_stall=1");
        end
    end

    initial begin
        rst_n = 1'b0; cfg_enable = 1'b0; cfg_interval = '0; cfg_starve_limit = 8'd3;
        force_check = 1'b0; list_nonempty = 1'b0; core_access = 1'b0; chk_done = 1'b0;
        chk_error = 1'b0; err_clr = 1'b0;

        // periodic launch, interval 10
        tbl.push_back(mk(2,  0, 10, 0, 1, 0, 0, Z));
        tbl.push_back(mk(1,  1, 10, 0, 1, 0, 0, Z));
        tbl.push_back(mk(10, 1, 10, 0, 1, 0, 0, Z));
        tbl.push_back(mk(1,  1, 10, 0, 1, 0, 0, ST));
        tbl.push_back(mk(1,  1, 10, 0, 1, 0, 1, GR));
        tbl.push_back(mk(9,  1, 10, 0, 1, 0, 0, Z));
        tbl.push_back(mk(1,  1, 10, 0, 1, 0, 0, ST));
        tbl.push_back(mk(1,  1, 10, 0, 1, 0, 1, GR));
        tbl.push_back(mk(9,  1, 10, 0, 1, 0, 0, Z));
        tbl.push_back(mk(1,  1, 10, 0, 1, 0, 0, ST));
        tbl.push_back(mk(1,  1, 10, 0, 1, 0, 1, GR));
        // empty list: interval wraps without launching, then launches on the wrap phase
        tbl.push_back(mk(20, 1, 5, 0, 0, 0, 0, Z));
        tbl.push_back(mk(4,  1, 5, 0, 1, 0, 0, Z));
        tbl.push_back(mk(1,  1, 5, 0, 1, 0, 0, ST));
        // starvation -> forced stall
        tbl.push_back(mk(3,  1, 0, 0, 1, 1, 0, RN));
        tbl.push_back(mk(4,  1, 0, 0, 1, 0, 0, SL));
        tbl.push_back(mk(1,  1, 0, 0, 1, 0, 0, GR));
        tbl.push_back(mk(1,  1, 0, 0, 1, 1, 0, RN));
        // force_check during RUN -> pending relaunch
        tbl.push_back(mk(1,  1, 0, 1, 1, 0, 0, GR));
        tbl.push_back(mk(4,  1, 0, 0, 1, 0, 0, GR));
        tbl.push_back(mk(1,  1, 0, 0, 1, 0, 1, GR));
        tbl.push_back(mk(1,  1, 0, 0, 1, 0, 0, Z));
        tbl.push_back(mk(1,  1, 0, 0, 1, 0, 0, ST));
        tbl.push_back(mk(1,  1, 0, 0, 1, 0, 1, GR));
        tbl.push_back(mk(5,  1, 0, 0, 1, 0, 0, Z));
        // chk_done beats the stall transition
        tbl.push_back(mk(1,  1, 0, 1, 1, 0, 0, Z));
        tbl.push_back(mk(1,  1, 0, 0, 1, 0, 0, ST));
        tbl.push_back(mk(2,  1, 0, 0, 1, 1, 0, RN));
        tbl.push_back(mk(1,  1, 0, 0, 1, 1, 1, RN));
        tbl.push_back(mk(2,  1, 0, 0, 1, 0, 0, Z));
        // enable dropped mid-check: finish, go IDLE, pend discarded
        tbl.push_back(mk(1,  1, 0, 1, 1, 0, 0, Z));
        tbl.push_back(mk(1,  1, 0, 0, 1, 0, 0, ST));
        tbl.push_back(mk(1,  0, 0, 1, 1, 0, 0, GR));
        tbl.push_back(mk(1,  0, 0, 0, 1, 0, 0, GR));
        tbl.push_back(mk(1,  0, 0, 0, 1, 0, 1, GR));
        tbl.push_back(mk(2,  0, 0, 1, 1, 0, 0, Z));
        tbl.push_back(mk(4,  1, 0, 0, 1, 0, 0, Z));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            apply(tbl[r], $sformatf("row%0d", r));
        end

        // error accounting
        check("err_count_reset", {24'd0, err_count}, 32'd0);
        check("err_irq_reset", {31'd0, err_irq}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk_error = 1'b1;
        end
        @(negedge clk);
        chk_error = 1'b0;
        #1;
        check("err_count_sat", {24'd0, err_count}, 32'd255);
        check("err_irq_set", {31'd0, err_irq}, 32'd1);
        @(negedge clk);
        chk_error = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        chk_error = 1'b0; err_clr = 1'b0;
        #1;
        check("err_count_clr_and_err", {24'd0, err_count}, 32'd1);
        check("err_irq_clr_and_err", {31'd0, err_irq}, 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("err_count_clr", {24'd0, err_count}, 32'd0);
        check("err_irq_clr", {31'd0, err_irq}, 32'd0);

        // async reset in the middle of a stall
        apply(mk(1, 1, 0, 1, 1, 0, 0, Z),  "rst_setup_count");
        apply(mk(1, 1, 0, 0, 1, 0, 0, ST), "rst_setup_start");
        apply(mk(3, 1, 0, 0, 1, 1, 0, RN), "rst_setup_run");
        apply(mk(2, 1, 0, 0, 1, 0, 0, SL), "rst_setup_stall");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_core_stall", {31'd0, core_stall}, 32'd0);
        check("rst_chk_grant", {31'd0, chk_grant}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        cfg_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(2, 0, 0, 0, 1, 0, 0, Z), "post_reset_idle");

`ifdef PLC_SCHED_TIMEOUT_EN
        begin
            int hit;
            hit = -1;
            apply(mk(1, 1, 0, 0, 1, 0, 0, Z),  "wd_idle");
            apply(mk(1, 1, 0, 1, 1, 0, 0, Z),  "wd_count");
            apply(mk(1, 1, 0, 0, 1, 0, 0, ST), "wd_start");
            for (int k = 1; k <= 1100; k++) begin
                @(negedge clk);
                #1;
                if (timeout_err) begin
                    hit = k;
                    break;
                end
            end
            check("timeout_cycle", hit, 1024);
            check("timeout_busy", {31'd0, busy}, 32'd0);
            check("timeout_grant", {31'd0, chk_grant}, 32'd0);
            @(negedge clk);
            #1;
            check("timeout_pulse_width", {31'd0, timeout_err}, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
